// File: rtl/mem_bus_responder_pkg.sv
// rtl/mem_bus_responder_pkg.sv - shared types and window decode for the memory bus responder
package mem_bus_responder_pkg;

    localparam int RESP_DATA_WIDTH   = 24;
    localparam int RESP_ID_WIDTH     = 4;
    localparam int BUS_ADDRESS_WIDTH = 32;

    typedef struct packed {
        logic [RESP_ID_WIDTH-1:0]   id;
        logic [RESP_DATA_WIDTH-1:0] data;
    } resp_t;

    // Extra bit on depth/offset so a window ending exactly at 2^ADDRESS_WIDTH still decodes.
    function automatic logic inWindow(
        input logic [BUS_ADDRESS_WIDTH-1:0] address,
        input logic [BUS_ADDRESS_WIDTH-1:0] base,
        input logic [BUS_ADDRESS_WIDTH:0]   depth
    );
        logic [BUS_ADDRESS_WIDTH:0] offset;
        offset = {1'b0, address} - {1'b0, base};
        return (address >= base) && (offset < depth);
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - MemoryBus request/response signal bundle
interface mem_bus_if #(
    parameter int DATA_WIDTH      = 24,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int MASTER_ID_WIDTH = 4
);
    logic [MASTER_ID_WIDTH-1:0] msID;
    logic [ADDRESS_WIDTH-1:0]   msAddress;
    logic [DATA_WIDTH-1:0]      msData;
    logic                       msWrite;
    logic                       msValid;
    logic                       msTaken;
    logic [MASTER_ID_WIDTH-1:0] smID;
    logic [DATA_WIDTH-1:0]      smData;
    logic                       smValid;
    logic                       smTaken;

    modport master (
        output msID, msAddress, msData, msWrite, msValid, smTaken,
        input  msTaken, smID, smData, smValid
    );

    modport slave (
        input  msID, msAddress, msData, msWrite, msValid, smTaken,
        output msTaken, smID, smData, smValid
    );
endinterface

// File: rtl/mem_bus_responder_fifo.sv
// rtl/mem_bus_responder_fifo.sv - first-word-fall-through response queue
module responder_fifo
    import mem_bus_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  resp_t                  pushData,
    input  logic                   pop,
    output logic                   headValid,
    output resp_t                  headData,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    resp_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && (count_q != CNT_W'(DEPTH));
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= pushData;
    end

    assign headValid = (count_q != '0);
    assign headData  = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - windowed RAM slave on the MemoryBus; MEM_BUS_RESPONDER_WRITE_ACK_EN adds write responses
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int                           DATA_WIDTH      = RESP_DATA_WIDTH,
    parameter int                           ADDRESS_WIDTH   = BUS_ADDRESS_WIDTH,
    parameter int                           MASTER_ID_WIDTH = RESP_ID_WIDTH,
    parameter logic [BUS_ADDRESS_WIDTH-1:0] BASE_ADDRESS    = '0,
    parameter int                           DEPTH           = 1024,
    parameter int                           RESP_DEPTH      = 4
) (
    input logic     clock,
    input logic     reset,
    mem_bus_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] ram_q [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  hit, credit, take, accept, resp_go, ram_we;
    logic                  in_flight_q, in_flight_d;
    resp_t                 resp_q, resp_d;
    logic [CNT_W-1:0]      fifo_count;
    logic                  head_valid, pop;
    resp_t                 head;

    assign hit = inWindow(bus.msAddress, BASE_ADDRESS, (ADDRESS_WIDTH + 1)'(DEPTH));
    // Low bits of the difference only depend on low bits of the operands.
    assign idx = bus.msAddress[IDX_W-1:0] - BASE_ADDRESS[IDX_W-1:0];

    // Credit counts the response still in the RAM stage; a pop this cycle is not yet visible.
    assign credit = (fifo_count + CNT_W'(in_flight_q)) < CNT_W'(RESP_DEPTH);

`ifdef MEM_BUS_RESPONDER_WRITE_ACK_EN
    assign take    = bus.msValid && hit && reset && credit;
    assign accept  = bus.msValid && take;
    assign resp_go = accept;
`else
    assign take    = bus.msValid && hit && reset && (bus.msWrite || credit);
    assign accept  = bus.msValid && take;
    assign resp_go = accept && !bus.msWrite;
`endif

    assign ram_we      = accept && bus.msWrite;
    assign bus.msTaken = take;

    always_comb begin
        in_flight_d = resp_go;
        resp_d      = resp_q;
        if (resp_go) begin
            resp_d.id   = bus.msID;
            resp_d.data = bus.msWrite ? bus.msData : ram_q[idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_flight_q <= 1'b0;
            resp_q      <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            resp_q      <= resp_d;
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we) ram_q[idx] <= bus.msData;
    end

    assign pop = head_valid && bus.smTaken;

    responder_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_flight_q),
        .pushData  (resp_q),
        .pop       (pop),
        .headValid (head_valid),
        .headData  (head),
        .count     (fifo_count)
    );

    // Gate the head so stale RAM contents never show while the queue is empty.
    assign bus.smValid = head_valid;
    assign bus.smID    = head_valid ? head.id   : '0;
    assign bus.smData  = head_valid ? head.data : '0;

endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - directed self-checking bench for mem_bus_responder
module tb_mem_bus_responder;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 1024;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_i;

    always #5 clock = ~clock;

    mem_bus_if bus ();

    mem_bus_responder #(.BASE_ADDRESS(BASE), .DEPTH(DEPTH), .RESP_DEPTH(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.msValid   = 1'b0;
        bus.msWrite   = 1'b0;
        bus.msID      = '0;
        bus.msAddress = '0;
        bus.msData    = '0;
    endtask

    task automatic set_req(input logic [3:0] id, input logic [31:0] addr,
                           input logic [23:0] data, input logic wr);
        bus.msID      = id;
        bus.msAddress = addr;
        bus.msData    = data;
        bus.msWrite   = wr;
        bus.msValid   = 1'b1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [23:0] data);
        set_req(id, addr, data, 1'b1);
        #1 check_eq("wr_taken", bus.msTaken, 1);
        @(negedge clock);
        idle_bus();
        @(negedge clock);
`ifdef MEM_BUS_RESPONDER_WRITE_ACK_EN
        #1 check_eq("wack_valid", bus.smValid, 1);
        check_eq("wack_id", bus.smID, id);
        check_eq("wack_data", bus.smData, data);
        bus.smTaken = 1'b1;
        @(negedge clock);
        bus.smTaken = 1'b0;
`else
        #1 check_eq("wr_no_resp", bus.smValid, 0);
`endif
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [23:0] exp);
        set_req(id, addr, 24'h0, 1'b0);
        #1 check_eq("rd_taken", bus.msTaken, 1);
        @(negedge clock);
        idle_bus();
        #1 check_eq("rd_not_yet", bus.smValid, 0);
        @(negedge clock);
        #1 check_eq("rd_valid", bus.smValid, 1);
        check_eq("rd_id", bus.smID, id);
        check_eq("rd_data", bus.smData, exp);
        bus.smTaken = 1'b1;
        @(negedge clock);
        bus.smTaken = 1'b0;
        #1 check_eq("rd_drained", bus.smValid, 0);
    endtask

    initial begin
        reset       = 1'b0;
        bus.smTaken = 1'b0;
        set_req(4'd1, BASE, 24'h0, 1'b0);
        #2;
        check_eq("rst_taken", bus.msTaken, 0);
        check_eq("rst_valid", bus.smValid, 0);
        check_eq("rst_id", bus.smID, 0);
        check_eq("rst_data", bus.smData, 0);
        @(negedge clock);
        idle_bus();
        reset = 1'b1;
        @(negedge clock);

        // write then read back with a different master ID
        do_write(4'd3, BASE + 32'd5, 24'h00ABCD);
        do_read(4'd7, BASE + 32'd5, 24'h00ABCD);

        for (int i = 0; i < 6; i++) do_write(4'd1, BASE + 32'(i), 24'h5A0000 + 24'(i));

        // back-pressure: four credits, then stall until drained
        bus.smTaken = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(4'd2, BASE + 32'(i), 24'h0, 1'b0);
            #1 check_eq($sformatf("bp_taken%0d", i), bus.msTaken, (i < 4) ? 32'd1 : 32'd0);
            @(negedge clock);
        end
        idle_bus();
        for (int i = 0; i < 4; i++) begin
            #1 check_eq($sformatf("bp_valid%0d", i), bus.smValid, 1);
            check_eq($sformatf("bp_data%0d", i), bus.smData, 24'h5A0000 + 24'(i));
            bus.smTaken = 1'b1;
            @(negedge clock);
        end
        bus.smTaken = 1'b0;
        #1 check_eq("bp_empty", bus.smValid, 0);
        do_read(4'd2, BASE + 32'd4, 24'h5A0004);
        do_read(4'd2, BASE + 32'd5, 24'h5A0005);

        // out-of-window addresses on both sides
        for (int a = 0; a < 2; a++) begin
            set_req(4'd4, (a == 0) ? BASE + 32'(DEPTH) : BASE - 32'd1, 24'h0, 1'b0);
            repeat (10) begin
                #1 check_eq($sformatf("miss%0d_taken", a), bus.msTaken, 0);
                check_eq($sformatf("miss%0d_valid", a), bus.smValid, 0);
                @(negedge clock);
            end
        end
        idle_bus();

        // read-after-write on consecutive cycles
        set_req(4'd3, BASE + 32'd9, 24'h111111, 1'b1);
        #1 check_eq("raw_wr_taken", bus.msTaken, 1);
        @(negedge clock);
        set_req(4'd6, BASE + 32'd9, 24'h0, 1'b0);
        #1 check_eq("raw_rd_taken", bus.msTaken, 1);
        @(negedge clock);
        idle_bus();
        @(negedge clock);
`ifdef MEM_BUS_RESPONDER_WRITE_ACK_EN
        #1 check_eq("raw_wack_data", bus.smData, 24'h111111);
        bus.smTaken = 1'b1;
        @(negedge clock);
        bus.smTaken = 1'b0;
`endif
        #1 check_eq("raw_valid", bus.smValid, 1);
        check_eq("raw_id", bus.smID, 6);
        check_eq("raw_data", bus.smData, 24'h111111);
        bus.smTaken = 1'b1;
        @(negedge clock);
        bus.smTaken = 1'b0;
        #1 check_eq("raw_empty", bus.smValid, 0);

        // async reset with two responses queued and a read on the bus
        set_req(4'd2, BASE, 24'h0, 1'b0);
        #1 check_eq("rr_taken0", bus.msTaken, 1);
        @(negedge clock);
        set_req(4'd2, BASE + 32'd1, 24'h0, 1'b0);
        #1 check_eq("rr_taken1", bus.msTaken, 1);
        @(negedge clock);
        idle_bus();
        @(negedge clock);
        #1 check_eq("rr_queued", bus.smValid, 1);
        set_req(4'd2, BASE + 32'd2, 24'h0, 1'b0);
        reset = 1'b0;
        #1 check_eq("rr_valid_low", bus.smValid, 0);
        check_eq("rr_taken_low", bus.msTaken, 0);
        check_eq("rr_data_low", bus.smData, 0);
        @(negedge clock);
        reset = 1'b1;
        idle_bus();
        #1 check_eq("rr_after_rel", bus.smValid, 0);
        @(negedge clock);
        #1 check_eq("rr_no_stale", bus.smValid, 0);
        do_read(4'd9, BASE + 32'd2, 24'h5A0002);

        // streaming with the master always ready
        bus.smTaken = 1'b1;
        exp_i = 0;
        for (int i = 0; i < 13; i++) begin
            if (i < 10) set_req(4'd5, BASE + 32'(i % 6), 24'h0, 1'b0);
            else        idle_bus();
            #1;
            if (i < 10) check_eq($sformatf("st_taken%0d", i), bus.msTaken, 1);
            check_eq("st_cnt_le2", 32'(u_dut.u_fifo.count <= 2), 1);
            if (bus.smValid) begin
                check_eq($sformatf("st_data%0d", exp_i), bus.smData, 24'h5A0000 + 24'(exp_i % 6));
                exp_i++;
            end
            @(negedge clock);
        end
        bus.smTaken = 1'b0;
        check_eq("st_count", 32'(exp_i), 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Slave/responder end of the MemoryBus request/response protocol that ray units and other masters drive.
- Accepts master-to-slave (ms) requests inside an address window and services them from an internal synchronous RAM.
- Returns read data tagged with the requesting master ID on the slave-to-master (sm) channel.
- Several responders share one bus, each with its own window; out-of-window requests are left for other slaves.

Parameters:
- DATA_WIDTH, 24, word width of msData/smData and RAM.
- ADDRESS_WIDTH, 32, bus address width.
- MASTER_ID_WIDTH, 4, width of msID/smID (minimum 1).
- BASE_ADDRESS, 0, first word address of the window.
- DEPTH, 1024, RAM words (power of two); window is [BASE_ADDRESS, BASE_ADDRESS+DEPTH).
- RESP_DEPTH, 4, response FIFO entries (power of two, at least 2).

Ports:
- clock, input, 1, sole clock; all state on rising edge.
- reset, input, 1, asynchronous, active-low reset.
- msID, input, MASTER_ID_WIDTH, requesting master ID.
- msAddress, input, ADDRESS_WIDTH, word address.
- msData, input, DATA_WIDTH, write data.
- msWrite, input, 1, 1 = write, 0 = read.
- msValid, input, 1, request valid.
- msTaken, output, 1, request accepted this cycle.
- smID, output, MASTER_ID_WIDTH, ID of the master owed this response.
- smData, output, DATA_WIDTH, read data.
- smValid, output, 1, response valid.
- smTaken, input, 1, master consumed the response.

Behaviour:
- Reset (reset=0, asynchronous):
  - msTaken=0, smValid=0, smID=0, smData=0.
  - FIFO empty; in-flight flag cleared.
  - RAM contents are not cleared.
  - Any in-flight read or queued response is dropped.
- Window decode:
  - hit = msAddress >= BASE_ADDRESS and msAddress - BASE_ADDRESS < DEPTH.
  - RAM index = low log2(DEPTH) bits of msAddress - BASE_ADDRESS.
- Acceptance:
  - msTaken is combinational: msTaken = msValid & hit & reset & (msWrite | credit).
  - credit = (fifoCount + inFlight) < RESP_DEPTH, computed from registered state only. A same-cycle smTaken pop does not add credit.
  - A transfer occurs when msValid & msTaken at a clock edge.
  - A miss never asserts msTaken; the request is ignored.
- Write: RAM[idx] <= msData at the accepting edge. No response is generated.
- Read pipeline:
  - Edge k: accept; RAM read issued; inFlight=1; ID captured.
  - Edge k+1: {ID, RAM data} pushed to FIFO.
  - With an empty FIFO, smValid=1 from edge k+1. Latency is 2 edges from acceptance to a takeable response.
  - One read per cycle is sustained while credit remains.
- Ordering and hazards:
  - Responses are returned strictly in acceptance order.
  - Read-after-write to the same address on consecutive cycles returns the new data.
- Response channel:
  - smValid/smID/smData come from the FIFO head and hold stable until smTaken.
  - A pop occurs when smValid & smTaken at an edge.
  - smTaken while smValid=0 is ignored.
  - A simultaneous push and pop keeps the count unchanged.
- Full FIFO: reads stall with msTaken=0; writes are still accepted.
- Widths: address comparison is unsigned at full ADDRESS_WIDTH, so BASE_ADDRESS+DEPTH may not exceed 2^ADDRESS_WIDTH.

Optional Feature:
- Macro: MEM_BUS_RESPONDER_WRITE_ACK_EN.
- Defined:
  - Every accepted write also produces a response {msID, msData} through the same FIFO, with the same 2-edge latency.
  - Writes then consume credit like reads.
- Undefined: writes are silent and need no credit, as specified above.

Decomposition:
- Package mem_bus_responder_pkg holds:
  - typedef struct resp_t {id, data}, parameterized through package localparams matching the defaults;
  - the function inWindow(address, base, depth).
- Sub-module responder_fifo:
  - synchronous, first-word-fall-through, RESP_DEPTH entries of resp_t;
  - ports: push, pushData, pop, headValid, headData, count.
- The top holds decode, the RAM, the in-flight register and the credit logic.

Test Plan:
- Write 0x00ABCD to BASE+5 from ID 3, then read BASE+5 from ID 7 -> read msTaken=1; smValid 2 edges later with smID=7, smData=0x00ABCD. No response for the write unless WRITE_ACK_EN.
- Hold smTaken=0 and issue 6 back-to-back reads of BASE+0..5 -> first 4 accepted; msTaken=0 thereafter. Raise smTaken -> data returns in order 0..3, then remaining reads accepted.
- Read at BASE+DEPTH and at BASE-1 -> msTaken stays 0 for 10 cycles; no smValid.
- Write 0x111111 to BASE+9, then read BASE+9 the next cycle -> smData=0x111111.
- With 2 responses queued, assert reset=0 mid-read for 1 cycle -> smValid=0 and msTaken=0 immediately. After release, a new read returns correct data and no stale responses appear.
- Streaming reads with smTaken=1 continuously -> one msTaken per cycle sustained; FIFO count never exceeds 2.
